// File: rtl/mm2st_arb_pkg.sv
// Shared definitions for the MM-to-ST stream arbiter.
//   arb_state_t   : arbiter FSM states (idle/arbitrate, granted).
//   DEF_NUM_SRC   : default number of requesting sources.
//   DEF_DATA_W    : default beat width.
//   ch_width()    : width of a channel/grant index for a given source count.
package mm2st_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    localparam int unsigned DEF_NUM_SRC = 4;
    localparam int unsigned DEF_DATA_W  = 16;

    // Never narrower than one bit, so two sources still get a real index.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mm2st_rr_pick.sv
// Combinational round-robin selector.
//   req    : per-source request vector.
//   rr_ptr : index that was served last (lowest priority this round).
//   found  : at least one request is set.
//   idx    : first requesting index scanning rr_ptr+1, rr_ptr+2, ... mod NUM_SRC.
module mm2st_rr_pick
    import mm2st_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC = DEF_NUM_SRC,
    parameter int unsigned CH_W    = ch_width(DEF_NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [CH_W-1:0]    rr_ptr,
    output logic               found,
    output logic [CH_W-1:0]    idx
);

    // Offsets are walked in priority order; the inner loop only matches the
    // candidate position so every index into req stays a constant.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            for (int unsigned j = 0; j < NUM_SRC; j++) begin
                if (!found && req[j] && (j == (32'(rr_ptr) + k) % NUM_SRC)) begin
                    found = 1'b1;
                    idx   = CH_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/mm2st_stream_arbiter.sv
// Packet-aware round-robin arbiter sharing one Avalon-ST path between
// NUM_SRC sources. A grant is held until the granted source's EOP beat is
// accepted, so packets never interleave. Output stage is registered.
//   avalon_st_clk / avalon_st_reset_n : clock, async active-low reset.
//   ctrl_enable      : allow new grants (current packet always completes).
//   sink_*           : per-source Avalon-ST sink ports (data packed by index).
//   source_*         : arbitrated Avalon-ST source, channel = origin index.
//   busy             : granted or holding an output beat.
//   pkt_count        : EOP beats accepted downstream (wrapping).
module mm2st_stream_arbiter
    import mm2st_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC = DEF_NUM_SRC,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CH_W    = ch_width(NUM_SRC)
) (
    input  logic                      avalon_st_clk,
    input  logic                      avalon_st_reset_n,
    input  logic                      ctrl_enable,
    input  logic [NUM_SRC*DATA_W-1:0] sink_data,
    input  logic [NUM_SRC-1:0]        sink_valid,
    input  logic [NUM_SRC-1:0]        sink_empty,
    input  logic [NUM_SRC-1:0]        sink_startofpacket,
    input  logic [NUM_SRC-1:0]        sink_endofpacket,
    output logic [NUM_SRC-1:0]        sink_ready,
    output logic [DATA_W-1:0]         source_data,
    output logic                      source_valid,
    output logic                      source_empty,
    output logic                      source_startofpacket,
    output logic                      source_endofpacket,
    output logic [CH_W-1:0]           source_channel,
    input  logic                      source_ready,
    output logic                      busy,
    output logic [31:0]               pkt_count
);

    arb_state_t        state;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   rr_ptr;

    logic              load_en;
    logic              beat_acc;
    logic              pick_found;
    logic [CH_W-1:0]   pick_idx;

    logic [DATA_W-1:0] sel_data;
    logic              sel_valid;
    logic              sel_empty;
    logic              sel_sop;
    logic              sel_eop;

    mm2st_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .CH_W    (CH_W)
    ) u_pick (
        .req    (sink_valid),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    // Output register can take a beat when empty or being drained this cycle.
    assign load_en = !source_valid || source_ready;

    always_comb begin
        sink_ready = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            sink_ready[i] = (state == ARB_GRANT) && load_en && (CH_W'(i) == grant);
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_empty = 1'b0;
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (CH_W'(i) == grant) begin
                sel_data  = sink_data[i*DATA_W +: DATA_W];
                sel_valid = sink_valid[i];
                sel_empty = sink_empty[i];
                sel_sop   = sink_startofpacket[i];
                sel_eop   = sink_endofpacket[i];
            end
        end
    end

    assign beat_acc = (state == ARB_GRANT) && sel_valid && load_en;

    always_ff @(posedge avalon_st_clk or negedge avalon_st_reset_n) begin
        if (!avalon_st_reset_n) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            rr_ptr <= CH_W'(NUM_SRC - 1);
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (ctrl_enable && pick_found) begin
                        grant <= pick_idx;
                        state <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (beat_acc && sel_eop) begin
                        rr_ptr <= grant;
                        state  <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge avalon_st_clk or negedge avalon_st_reset_n) begin
        if (!avalon_st_reset_n) begin
            source_valid         <= 1'b0;
            source_data          <= '0;
            source_empty         <= 1'b0;
            source_startofpacket <= 1'b0;
            source_endofpacket   <= 1'b0;
            source_channel       <= '0;
        end else if (load_en) begin
            source_valid <= beat_acc;
            if (beat_acc) begin
                source_data          <= sel_data;
                source_empty         <= sel_empty;
                source_startofpacket <= sel_sop;
                source_endofpacket   <= sel_eop;
                source_channel       <= grant;
            end
        end
    end

    always_ff @(posedge avalon_st_clk or negedge avalon_st_reset_n) begin
        if (!avalon_st_reset_n) begin
            pkt_count <= '0;
        end else if (source_valid && source_ready && source_endofpacket) begin
            pkt_count <= pkt_count + 32'd1;
        end
    end

    assign busy = (state == ARB_GRANT) || source_valid;

endmodule

// File: tb/tb_mm2st_stream_arbiter.sv
module tb_mm2st_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int CW = 2;

    typedef struct packed {
        logic [15:0] d;
        logic        sop;
        logic        eop;
        logic        emp;
    } beat_t;

    typedef struct {
        int    ch;
        beat_t b;
        int    cyc;
    } log_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            ctrl_enable;
    logic [N*DW-1:0] sink_data;
    logic [N-1:0]    sink_valid, sink_empty, sink_sop, sink_eop, sink_ready;
    logic [DW-1:0]   source_data;
    logic            source_valid, source_empty, source_sop, source_eop;
    logic [CW-1:0]   source_channel;
    logic            source_ready;
    logic            busy;
    logic [31:0]     pkt_count;

    mm2st_stream_arbiter #(
        .NUM_SRC (N),
        .DATA_W  (DW)
    ) dut (
        .avalon_st_clk        (clk),
        .avalon_st_reset_n    (rst_n),
        .ctrl_enable          (ctrl_enable),
        .sink_data            (sink_data),
        .sink_valid           (sink_valid),
        .sink_empty           (sink_empty),
        .sink_startofpacket   (sink_sop),
        .sink_endofpacket     (sink_eop),
        .sink_ready           (sink_ready),
        .source_data          (source_data),
        .source_valid         (source_valid),
        .source_empty         (source_empty),
        .source_startofpacket (source_sop),
        .source_endofpacket   (source_eop),
        .source_channel       (source_channel),
        .source_ready         (source_ready),
        .busy                 (busy),
        .pkt_count            (pkt_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    beat_t       srcq[N][$];
    log_t        olog[$];
    logic [N-1:0] pop_mask = '0;
    bit          use_pat = 0;
    int          pat_i = 0;
    bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the path (-1 = nobody), who was served
    // last, and what single beat sits in the output slot.
    int          m_owner, m_last, m_ch;
    bit          m_v;
    beat_t       m_b;
    logic [31:0] m_pkt;

    always @(posedge clk or negedge rst_n) begin : model
        bit load, acc, took;
        int cand;
        if (!rst_n) begin
            m_owner = -1;
            m_last  = N - 1;
            m_v     = 0;
            m_b     = '0;
            m_ch    = 0;
            m_pkt   = '0;
        end else begin
            load = !m_v || source_ready;
            acc  = (m_owner >= 0) && sink_valid[m_owner] && load;
            if (m_v && source_ready && m_b.eop) m_pkt = m_pkt + 1;
            if (acc) begin
                if (sink_eop[m_owner]) begin
                    m_last = m_owner;
                end
            end
            if (load) begin
                m_v = acc;
                if (acc) begin
                    m_b.d   = sink_data[m_owner*DW +: DW];
                    m_b.sop = sink_sop[m_owner];
                    m_b.eop = sink_eop[m_owner];
                    m_b.emp = sink_empty[m_owner];
                    m_ch    = m_owner;
                end
            end
            if (m_owner < 0) begin
                took = 0;
                if (ctrl_enable) begin
                    for (int k = 1; k <= N; k++) begin
                        cand = (m_last + k) % N;
                        if (!took && sink_valid[cand]) begin
                            took    = 1;
                            m_owner = cand;
                        end
                    end
                end
            end else if (acc && sink_eop[m_owner]) begin
                m_owner = -1;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [N-1:0] exp_rdy;
        log_t e;
        pop_mask = '0;
        if (rst_n) begin
            exp_rdy = '0;
            if (m_owner >= 0 && (!m_v || source_ready)) exp_rdy[m_owner] = 1'b1;
            check("sink_ready", 64'(sink_ready), 64'(exp_rdy));
            check("source_valid", 64'(source_valid), 64'(m_v));
            check("busy", 64'(busy), 64'((m_owner >= 0) || m_v));
            check("pkt_count", 64'(pkt_count), 64'(m_pkt));
            if (m_v) begin
                check("source_data", 64'(source_data), 64'(m_b.d));
                check("source_sop", 64'(source_sop), 64'(m_b.sop));
                check("source_eop", 64'(source_eop), 64'(m_b.eop));
                check("source_empty", 64'(source_empty), 64'(m_b.emp));
                check("source_channel", 64'(source_channel), 64'(m_ch));
            end
            pop_mask = sink_ready & sink_valid;
            if (source_valid && source_ready) begin
                e.ch    = int'(source_channel);
                e.b.d   = source_data;
                e.b.sop = source_sop;
                e.b.eop = source_eop;
                e.b.emp = source_empty;
                e.cyc   = cyc;
                olog.push_back(e);
            end
        end
    end

    task automatic drive();
        beat_t b;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                b = srcq[i][0];
                sink_valid[i]        = 1'b1;
                sink_data[i*DW +: DW] = b.d;
                sink_sop[i]          = b.sop;
                sink_eop[i]          = b.eop;
                sink_empty[i]        = b.emp;
            end else begin
                sink_valid[i]        = 1'b0;
                sink_data[i*DW +: DW] = '0;
                sink_sop[i]          = 1'b0;
                sink_eop[i]          = 1'b0;
                sink_empty[i]        = 1'b0;
            end
        end
    endtask

    task automatic push_pkt(input int src, input int n, input logic [15:0] base, input logic emp_last);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.d   = 16'(base + 16'(k));
            b.sop = (k == 0);
            b.eop = (k == n - 1);
            b.emp = (k == n - 1) ? emp_last : 1'b0;
            srcq[src].push_back(b);
        end
    endtask

    task automatic cyc1();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (pop_mask[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        end
        if (use_pat) begin
            source_ready = pat[pat_i % 4];
            pat_i++;
        end
        drive();
    endtask

    function automatic bit model_idle();
        bit r = (m_owner < 0) && !m_v;
        for (int i = 0; i < N; i++) if (srcq[i].size() > 0) r = 0;
        return r;
    endfunction

    task automatic drain(input string nm);
        int k = 0;
        while (!model_idle() && k < 200) begin
            cyc1();
            k++;
        end
        check(nm, 64'(model_idle()), 64'd1);
    endtask

    // Mid-cycle async reset; outputs must clear without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_source_valid", 64'(source_valid), 64'd0);
        check("rst_sink_ready", 64'(sink_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_source_data", 64'(source_data), 64'd0);
        check("rst_source_flags", 64'({source_sop, source_eop, source_empty}), 64'd0);
        check("rst_source_channel", 64'(source_channel), 64'd0);
        for (int i = 0; i < N; i++) srcq[i].delete();
        drive();
        olog.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [15:0] exp3[5] = '{16'hA001, 16'hA002, 16'hA003, 16'hB001, 16'hB002};
        int          ch3[5]  = '{1, 1, 1, 2, 2};

        ctrl_enable  = 1'b1;
        source_ready = 1'b1;
        drive();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single 3-beat packet from source 0.
        push_pkt(0, 3, 16'h0001, 1'b0);
        drive();
        t0 = cyc;
        drain("t1_drain");
        check("t1_beats", 64'(olog.size()), 64'd3);
        if (olog.size() == 3) begin
            check("t1_latency", 64'(olog[0].cyc - t0), 64'd2);
            check("t1_d0", 64'(olog[0].b.d), 64'h0001);
            check("t1_d2", 64'(olog[2].b.d), 64'h0003);
            check("t1_sop0", 64'(olog[0].b.sop), 64'd1);
            check("t1_eop2", 64'(olog[2].b.eop), 64'd1);
            check("t1_eop0", 64'(olog[0].b.eop), 64'd0);
            check("t1_ch", 64'(olog[1].ch), 64'd0);
        end
        check("t1_pkt_count", 64'(pkt_count), 64'd1);

        // All four sources hold 2-beat packets from reset.
        do_reset();
        for (int i = 0; i < N; i++) push_pkt(i, 2, 16'((i + 1) * 256 + 1), 1'b0);
        drive();
        t0 = cyc;
        drain("t2_drain");
        check("t2_beats", 64'(olog.size()), 64'd8);
        if (olog.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                check("t2_ch", 64'(olog[k].ch), 64'(k / 2));
                check("t2_data", 64'(olog[k].b.d), 64'((k / 2 + 1) * 256 + k % 2 + 1));
            end
            check("t2_latency", 64'(olog[0].cyc - t0), 64'd2);
            check("t2_back_to_back", 64'(olog[1].cyc - olog[0].cyc), 64'd1);
            check("t2_bubble", 64'(olog[2].cyc - olog[1].cyc), 64'd2);
        end
        check("t2_pkt_count", 64'(pkt_count), 64'd4);

        // Backpressure 1,0,0,1 with source 2 waiting behind source 1.
        olog.delete();
        push_pkt(1, 3, 16'hA001, 1'b0);
        push_pkt(2, 2, 16'hB001, 1'b0);
        use_pat = 1;
        pat_i   = 0;
        drive();
        drain("t3_drain");
        use_pat      = 0;
        source_ready = 1'b1;
        check("t3_beats", 64'(olog.size()), 64'd5);
        if (olog.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                check("t3_data", 64'(olog[k].b.d), 64'(exp3[k]));
                check("t3_ch", 64'(olog[k].ch), 64'(ch3[k]));
            end
        end
        check("t3_pkt_count", 64'(pkt_count), 64'd6);

        // ctrl_enable dropped mid-packet from source 3.
        olog.delete();
        push_pkt(3, 4, 16'hC001, 1'b0);
        drive();
        repeat (3) cyc1();
        ctrl_enable = 1'b0;
        push_pkt(0, 2, 16'hD001, 1'b0);
        push_pkt(1, 1, 16'hE001, 1'b0);
        drive();
        repeat (10) cyc1();
        check("t4_beats_disabled", 64'(olog.size()), 64'd4);
        if (olog.size() == 4) check("t4_last_ch", 64'(olog[3].ch), 64'd3);
        check("t4_no_grant", 64'(sink_ready), 64'd0);
        check("t4_idle_busy", 64'(busy), 64'd0);
        check("t4_pkt_mid", 64'(pkt_count), 64'd7);
        ctrl_enable = 1'b1;
        drain("t4_drain");
        check("t4_beats", 64'(olog.size()), 64'd7);
        if (olog.size() == 7) begin
            check("t4_resume_ch", 64'(olog[4].ch), 64'd0);
            check("t4_resume_d", 64'(olog[4].b.d), 64'hD001);
            check("t4_next_ch", 64'(olog[6].ch), 64'd1);
        end
        check("t4_pkt_count", 64'(pkt_count), 64'd9);

        // Back-to-back single-beat packets with empty=1 from source 2.
        olog.delete();
        for (int j = 0; j < 3; j++) push_pkt(2, 1, 16'(16'hF001 + j), 1'b1);
        drive();
        drain("t5_drain");
        check("t5_beats", 64'(olog.size()), 64'd3);
        if (olog.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                check("t5_flags", 64'({olog[k].b.sop, olog[k].b.eop, olog[k].b.emp}), 64'b111);
                check("t5_ch", 64'(olog[k].ch), 64'd2);
                check("t5_data", 64'(olog[k].b.d), 64'(16'hF001 + k));
            end
            check("t5_spacing", 64'(olog[1].cyc - olog[0].cyc), 64'd2);
        end
        check("t5_pkt_count", 64'(pkt_count), 64'd12);

        // Reset mid-packet, then a fresh packet.
        push_pkt(0, 4, 16'h1101, 1'b0);
        drive();
        repeat (3) cyc1();
        check("t6_busy_before", 64'(busy), 64'd1);
        do_reset();
        push_pkt(0, 2, 16'h2201, 1'b0);
        drive();
        t0 = cyc;
        drain("t6_drain");
        check("t6_beats", 64'(olog.size()), 64'd2);
        if (olog.size() == 2) begin
            check("t6_latency", 64'(olog[0].cyc - t0), 64'd2);
            check("t6_d0", 64'(olog[0].b.d), 64'h2201);
            check("t6_d1", 64'(olog[1].b.d), 64'h2202);
            check("t6_ch", 64'(olog[0].ch), 64'd0);
        end
        check("t6_pkt_count", 64'(pkt_count), 64'd1);

        repeat (2) cyc1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mm2st_stream_arbiter.md
Name: mm2st_stream_arbiter

Overview:
- Packet-aware round-robin arbiter that shares the single 16-bit Avalon-ST path into the MM-to-ST data adapter between NUM_SRC upstream requesters (DMA readers, test-pattern generator, etc.).
- Grants one source at a time and holds the grant until that source's endofpacket beat is accepted, so packets never interleave.
- Registered output stage; channel index is forwarded so downstream can tag sample origin.

Parameters:
- NUM_SRC, 4, number of requesting sink ports (2..8).
- DATA_W, 16, data width per beat.
- CH_W, $clog2(NUM_SRC), width of the channel/grant index.

Ports:
- avalon_st_clk  in  1  single clock for all logic.
- avalon_st_reset_n  in  1  asynchronous, active-low reset.
- ctrl_enable  in  1  1 = new grants allowed; 0 = finish current packet, then idle.
- sink_data  in  NUM_SRC*DATA_W  packed data, source i at [i*DATA_W +: DATA_W].
- sink_valid  in  NUM_SRC  per-source valid.
- sink_empty  in  NUM_SRC  per-source empty.
- sink_startofpacket  in  NUM_SRC  per-source SOP.
- sink_endofpacket  in  NUM_SRC  per-source EOP.
- sink_ready  out  NUM_SRC  per-source ready; at most one bit set.
- source_data  out  DATA_W  arbitrated data.
- source_valid  out  1  output valid.
- source_empty  out  1  forwarded empty.
- source_startofpacket  out  1  forwarded SOP.
- source_endofpacket  out  1  forwarded EOP.
- source_channel  out  CH_W  index of the source that produced the beat.
- source_ready  in  1  downstream ready.
- busy  out  1  high while in GRANT state or output register holds a beat.
- pkt_count  out  32  packets forwarded (EOP beats accepted on output); wraps at 2^32-1 -> 0.

Behaviour:
- Reset (async assert, sync-free deassert into flops): state=IDLE, grant=0, rr_ptr=NUM_SRC-1, all source_* outputs 0, sink_ready=0, busy=0, pkt_count=0. Reset mid-packet discards the in-flight packet; no recovery beats are emitted.
- Output register: load_en = !source_valid || source_ready. Beat accepted from granted sink when sink_valid[grant] && sink_ready[grant]; it appears on source_* the next cycle. source_valid clears on source_ready with no new load.
- sink_ready[i] = (state==GRANT) && (i==grant) && load_en; all other bits 0. Purely combinational from state and source_ready.
- FSM IDLE: if ctrl_enable && |sink_valid, pick first valid index scanning rr_ptr+1, rr_ptr+2, ... (mod NUM_SRC); register grant, go GRANT. No sink_ready in IDLE (one arbitration cycle).
- FSM GRANT: forward beats from grant. On accepted beat with EOP=1: rr_ptr<=grant, go IDLE. ctrl_enable deassert does not abort GRANT.
- SOP not required to open a grant; a lone EOP beat closes it. A beat with SOP=EOP=1 is a one-beat packet: GRANT for one accepted beat, then IDLE.
- Latency: sink_valid rising in IDLE at cycle 0 -> sink_ready at cycle 1 -> source_valid at cycle 2 (with source_ready held high). One bubble cycle between consecutive packets (IDLE re-arbitration).
- Throughput within a packet: one beat per cycle while source_ready=1; backpressure propagates same cycle via load_en.
- pkt_count increments when source_valid && source_ready && source_endofpacket.
- busy = (state==GRANT) || source_valid.
- Simultaneous requests: round-robin fairness; a source that just finished has lowest priority next.

Decomposition:
- Package mm2st_arb_pkg: state enum (ARB_IDLE, ARB_GRANT), CH_W function/constant, default NUM_SRC/DATA_W constants.
- One sub-module: mm2st_rr_pick (combinational round-robin selector: req vector + rr_ptr -> found, index). FSM, mux and output register stay in the top.

Test Plan:
- Single source 0 sends 3-beat packet 0x0001,0x0002,0x0003 with source_ready=1 -> first output beat 2 cycles after valid, SOP on 0x0001, EOP on 0x0003, channel=0, pkt_count=1.
- Sources 0..3 all hold 2-beat packets from reset -> packets emerge in order ch0,ch1,ch2,ch3, no interleave, one idle cycle between packets, pkt_count=4.
- Source 1 mid-packet while source 2 requests; source_ready toggles 1,0,0,1 -> no beat lost or duplicated, sink_ready[1] mirrors load_en, source 2 granted only after source 1 EOP.
- ctrl_enable dropped during 4-beat packet from source 3 -> packet completes, then no grant while sources valid; re-enable -> grant resumes at ch0 (rr after 3).
- Single-beat packets (SOP=EOP=1, empty=1) from source 2 back-to-back -> each forwarded with empty=1, state returns IDLE each time.
- Assert avalon_st_reset_n=0 mid-packet -> all outputs 0 asynchronously, pkt_count=0; after release a fresh packet from source 0 is forwarded normally.
